// File: rtl/core_dma.sv
// Multi-channel DMA engine: halts the CPU via O_ready, then performs block copies
// or single-byte fetches on the CPU bus, one bus cycle per I_cycle strobe.
module core_dma #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned LEN_WIDTH = 8,
  parameter bit          ALIGN     = 1'b1
) (
  input  logic                            I_clock,
  input  logic                            I_reset,
  input  logic                            I_cycle,
  input  logic                            I_cpu_rdwr,
  input  logic [7:0]                      I_rd_data,
  input  logic [CHANNELS-1:0]             I_req,
  input  logic [2*CHANNELS-1:0]           I_mode,
  input  logic [16*CHANNELS-1:0]          I_src,
  input  logic [16*CHANNELS-1:0]          I_dst,
  input  logic [LEN_WIDTH*CHANNELS-1:0]   I_len,
  output logic                            O_ready,
  output logic                            O_bus_en,
  output logic [15:0]                     O_addr,
  output logic [7:0]                      O_wr_data,
  output logic                            O_rdwr,
  output logic [CHANNELS-1:0]             O_busy,
  output logic [CHANNELS-1:0]             O_done,
  output logic [7:0]                      O_fetch_data,
  output logic                            O_fetch_valid
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_FETCH, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CHANNELS-1:0]   pend_q, pend_d;
  logic                  parity_q, parity_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           src_q, src_d;
  logic [15:0]           dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  bus_en_q, bus_en_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  rdwr_q, rdwr_d;
  logic [CHANNELS-1:0]   done_q, done_d;
  logic [7:0]            fetch_data_q, fetch_data_d;
  logic                  fetch_valid_q, fetch_valid_d;

  logic                  grant_any;
  logic [CH_W-1:0]       grant_ch;
  int unsigned           grant_sel;
  logic [1:0]            g_mode;
  logic [15:0]           g_src;
  logic [15:0]           g_dst;
  logic [LEN_WIDTH-1:0]  g_len;

  function automatic state_e first_state(input logic [1:0] m, input logic par);
    if (m[1])
      return S_FETCH;
    else if (ALIGN && par)
      return S_ALIGN;
    return S_READ;
  endfunction

  // Fixed priority: lowest-index requester; a same-clock request also counts so
  // the halt can start one clock after I_req.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if ((pend_q[i] || I_req[i]) && !grant_any) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(i);
      end
    end
    grant_sel = 32'(grant_ch);
    g_mode    = I_mode[2*grant_sel +: 2];
    g_src     = I_src[16*grant_sel +: 16];
    g_dst     = I_dst[16*grant_sel +: 16];
    g_len     = I_len[LEN_WIDTH*grant_sel +: LEN_WIDTH];
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    pend_d        = pend_q | I_req;
    parity_d      = parity_q ^ I_cycle;
    mode_d        = mode_q;
    src_d         = src_q;
    dst_d         = dst_q;
    cnt_d         = cnt_q;
    ready_d       = ready_q;
    bus_en_d      = bus_en_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    rdwr_d        = rdwr_q;
    done_d        = '0;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = S_HALT;
          ready_d = 1'b0;
          ch_d    = grant_ch;
          mode_d  = g_mode;
          src_d   = g_src;
          dst_d   = g_dst;
          cnt_d   = g_len;
        end
      end
      S_HALT: begin
        if (I_cycle && I_cpu_rdwr) begin
          state_d  = first_state(mode_q, parity_d);
          bus_en_d = 1'b1;
          rdwr_d   = 1'b1;
          addr_d   = src_q;
        end
      end
      S_ALIGN: begin
        if (I_cycle)
          state_d = S_READ;
      end
      S_READ: begin
        if (I_cycle) begin
          wr_data_d = I_rd_data;
          rdwr_d    = 1'b0;
          addr_d    = dst_q;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (I_cycle) begin
          src_d  = src_q + 16'd1;
          dst_d  = mode_q[0] ? dst_q : dst_q + 16'd1;
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          rdwr_d = 1'b1;
          addr_d = src_q + 16'd1;
          // A loaded count of zero wraps through all 2**LEN_WIDTH values.
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d      = S_DONE;
            pend_d[ch_q] = 1'b0;
            done_d[ch_q] = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_FETCH: begin
        if (I_cycle) begin
          fetch_data_d  = I_rd_data;
          fetch_valid_d = 1'b1;
          state_d       = S_DONE;
          pend_d[ch_q]  = 1'b0;
          done_d[ch_q]  = 1'b1;
        end
      end
      S_DONE: begin
        if (grant_any) begin
          state_d  = first_state(g_mode, parity_d);
          ch_d     = grant_ch;
          mode_d   = g_mode;
          src_d    = g_src;
          dst_d    = g_dst;
          cnt_d    = g_len;
          bus_en_d = 1'b1;
          rdwr_d   = 1'b1;
          addr_d   = g_src;
        end else begin
          state_d  = S_IDLE;
          ready_d  = 1'b1;
          bus_en_d = 1'b0;
          rdwr_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      pend_q        <= '0;
      parity_q      <= 1'b0;
      mode_q        <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      bus_en_q      <= 1'b0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      rdwr_q        <= 1'b1;
      done_q        <= '0;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      pend_q        <= pend_d;
      parity_q      <= parity_d;
      mode_q        <= mode_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      bus_en_q      <= bus_en_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      rdwr_q        <= rdwr_d;
      done_q        <= done_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign O_ready       = ready_q;
  assign O_bus_en      = bus_en_q;
  assign O_addr        = addr_q;
  assign O_wr_data     = wr_data_q;
  assign O_rdwr        = rdwr_q;
  assign O_busy        = pend_q;
  assign O_done        = done_q;
  assign O_fetch_data  = fetch_data_q;
  assign O_fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_core_dma.sv
// Directed bench for core_dma: expected bus transactions are queued at request time
// and checked at every bus-cycle strobe the DMA owns.
module tb_core_dma;

  typedef struct packed {
    logic        rdwr;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_t;

  logic        clk = 1'b0;
  logic        I_reset = 1'b0;
  logic        I_cycle = 1'b0;
  logic        I_cpu_rdwr = 1'b1;
  logic [7:0]  rd_data;
  logic [1:0]  I_req = '0;
  logic [3:0]  I_mode = '0;
  logic [31:0] I_src = '0;
  logic [31:0] I_dst = '0;
  logic [15:0] I_len = '0;
  logic        O_ready, O_bus_en, O_rdwr, O_fetch_valid;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data, O_fetch_data;
  logic [1:0]  O_busy, O_done;

  logic [1:0]  na_req = '0;
  logic [7:0]  na_rd_data;
  logic        na_ready, na_bus_en, na_rdwr, na_fetch_valid;
  logic [15:0] na_addr;
  logic [7:0]  na_wr_data, na_fetch_data;
  logic [1:0]  na_busy, na_done;

  int total = 0;
  int bad = 0;
  bus_t sb[$];
  logic [7:0] fetch_log[$];
  int done_log[$];
  int bus_cycles = 0, ready_low = 0, ready_rises = 0;
  int done0 = 0, done1 = 0, na_cycles = 0, na_done_cnt = 0;
  logic prev_ready = 1'b1;
  int n_strobe = 0;
  int unsigned cyc_div = 0;

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    if (a == 16'hC000) return 8'h5A;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  assign rd_data    = rd_fn(O_addr);
  assign na_rd_data = rd_fn(na_addr);

  core_dma #(.CHANNELS(2), .LEN_WIDTH(8), .ALIGN(1'b1)) u_dut (
    .I_clock(clk), .I_reset(I_reset), .I_cycle(I_cycle), .I_cpu_rdwr(I_cpu_rdwr),
    .I_rd_data(rd_data), .I_req(I_req), .I_mode(I_mode), .I_src(I_src), .I_dst(I_dst),
    .I_len(I_len), .O_ready(O_ready), .O_bus_en(O_bus_en), .O_addr(O_addr),
    .O_wr_data(O_wr_data), .O_rdwr(O_rdwr), .O_busy(O_busy), .O_done(O_done),
    .O_fetch_data(O_fetch_data), .O_fetch_valid(O_fetch_valid)
  );

  core_dma #(.CHANNELS(2), .LEN_WIDTH(8), .ALIGN(1'b0)) u_dut_na (
    .I_clock(clk), .I_reset(I_reset), .I_cycle(I_cycle), .I_cpu_rdwr(I_cpu_rdwr),
    .I_rd_data(na_rd_data), .I_req(na_req), .I_mode(I_mode), .I_src(I_src), .I_dst(I_dst),
    .I_len(I_len), .O_ready(na_ready), .O_bus_en(na_bus_en), .O_addr(na_addr),
    .O_wr_data(na_wr_data), .O_rdwr(na_rdwr), .O_busy(na_busy), .O_done(na_done),
    .O_fetch_data(na_fetch_data), .O_fetch_valid(na_fetch_valid)
  );

  always #5 clk = ~clk;

  // Bus-cycle strobe every 4 clocks, changed just after the rising edge.
  always @(posedge clk) begin
    #2;
    cyc_div = (cyc_div + 1) % 4;
    I_cycle = (cyc_div == 0);
  end

  // Reference bus-cycle parity: strobes seen since reset.
  always @(posedge clk or negedge I_reset) begin
    if (!I_reset) n_strobe <= 0;
    else if (I_cycle) n_strobe <= n_strobe + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard/monitor: every DMA-owned bus cycle is compared at its closing strobe.
  always @(negedge clk) begin
    if (I_reset) begin
      if (I_cycle && O_bus_en) begin
        bus_cycles++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL bus_unexpected observed=%0h expected=none", {O_rdwr, O_addr});
        end else begin
          bus_t e;
          e = sb.pop_front();
          check("bus", {39'd0, O_rdwr, O_addr, (O_rdwr ? 8'h00 : O_wr_data)}, {39'd0, e});
        end
      end
      if (I_cycle && !O_ready) ready_low++;
      if (O_ready && !prev_ready) ready_rises++;
      prev_ready = O_ready;
      if (O_done[0]) begin done0++; done_log.push_back(0); end
      if (O_done[1]) begin done1++; done_log.push_back(1); end
      if (O_fetch_valid) fetch_log.push_back(O_fetch_data);
      if (I_cycle && na_bus_en) na_cycles++;
      if (na_done[0]) na_done_cnt++;
    end
  end

  task automatic set_ch(input int c, input logic [1:0] m, input logic [15:0] s,
                        input logic [15:0] d, input logic [7:0] l);
    I_mode[2*c +: 2]  = m;
    I_src[16*c +: 16] = s;
    I_dst[16*c +: 16] = d;
    I_len[8*c +: 8]   = l;
  endtask

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                           input logic fixed_dst, input logic aligned);
    logic [15:0] sa, da;
    sa = s;
    da = d;
    if (aligned) sb.push_back('{1'b1, s, 8'h00});
    for (int i = 0; i < n; i++) begin
      sb.push_back('{1'b1, sa, 8'h00});
      sb.push_back('{1'b0, da, rd_fn(sa)});
      sa = sa + 16'd1;
      if (!fixed_dst) da = da + 16'd1;
    end
  endtask

  task automatic clear_counts();
    bus_cycles = 0; ready_low = 0; ready_rises = 0; done0 = 0; done1 = 0;
    na_cycles = 0; na_done_cnt = 0;
    done_log.delete();
    fetch_log.delete();
  endtask

  // Returns at the falling edge just after the next strobe has been applied.
  task automatic next_cycle();
    int n;
    n = 0;
    @(negedge clk);
    while (!I_cycle && n < 16) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  // Position so that the bus cycle following the k-th upcoming strobe has parity `want`.
  task automatic sync_parity(input int want, input int k);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (((n_strobe + k) % 2) == want) break;
    end
  endtask

  task automatic pulse_req(input logic [1:0] r, input logic [1:0] nr);
    I_req = r;
    na_req = nr;
    @(negedge clk);
    I_req = '0;
    na_req = '0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while ((done0 + done1) < target && n < budget) begin @(negedge clk); n++; end
    if ((done0 + done1) < target) begin
      total++;
      bad++;
      $error("FAIL timeout_done observed=%0d expected=%0d", done0 + done1, target);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {24'd0, O_ready, O_bus_en, O_rdwr, O_addr, O_wr_data, O_busy, O_done,
                O_fetch_data, O_fetch_valid},
               {24'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outs("reset_values");
    I_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Ch0 copy 256 bytes, fixed dst, even parity.
    set_ch(0, 2'b01, 16'h0200, 16'h2004, 8'h00);
    sync_parity(0, 1);
    push_copy(16'h0200, 16'h2004, 256, 1'b1, 1'b0);
    clear_counts();
    pulse_req(2'b01, 2'b00);
    check("ready_fall", 64'(O_ready), 64'd0);
    check("busy_ch0", 64'(O_busy), 64'd1);
    wait_done(1, 4000);
    check("even_cycles", 64'(bus_cycles), 64'd512);
    check("even_done", 64'(done0), 64'd1);
    check("even_drained", 64'(sb.size()), 64'd0);
    check("even_idle", {62'd0, O_ready, O_bus_en}, {62'd0, 1'b1, 1'b0});

    // Same copy on odd parity; the ALIGN=0 instance runs alongside.
    sync_parity(1, 1);
    push_copy(16'h0200, 16'h2004, 256, 1'b1, 1'b1);
    clear_counts();
    pulse_req(2'b01, 2'b01);
    wait_done(1, 4000);
    check("odd_cycles", 64'(bus_cycles), 64'd513);
    check("odd_drained", 64'(sb.size()), 64'd0);
    check("noalign_cycles", 64'(na_cycles), 64'd512);
    check("noalign_done", 64'(na_done_cnt), 64'd1);

    // Ch1 single fetch.
    set_ch(1, 2'b10, 16'hC000, 16'h0000, 8'h00);
    sync_parity(0, 1);
    sb.push_back('{1'b1, 16'hC000, 8'h00});
    clear_counts();
    pulse_req(2'b10, 2'b00);
    wait_done(1, 100);
    check("fetch_pulses", 64'(fetch_log.size()), 64'd1);
    if (fetch_log.size() > 0) check("fetch_data", 64'(fetch_log[0]), 64'h5A);
    check("fetch_ready_low", 64'(ready_low), 64'd2);
    check("fetch_cycles", 64'(bus_cycles), 64'd1);
    check("fetch_done1", 64'(done1), 64'd1);

    // Simultaneous requests: ch0 copy of 3, then ch1 fetch without re-halting.
    set_ch(0, 2'b00, 16'h0400, 16'h0500, 8'd3);
    sync_parity(0, 1);
    push_copy(16'h0400, 16'h0500, 3, 1'b0, 1'b0);
    sb.push_back('{1'b1, 16'hC000, 8'h00});
    clear_counts();
    pulse_req(2'b11, 2'b00);
    check("dual_busy", 64'(O_busy), 64'd3);
    wait_done(2, 200);
    check("dual_order0", 64'(done_log.size() > 0 ? done_log[0] : -1), 64'd0);
    check("dual_order1", 64'(done_log.size() > 1 ? done_log[1] : -1), 64'd1);
    check("dual_ready_rises", 64'(ready_rises), 64'd1);
    check("dual_ready_low", 64'(ready_low), 64'd8);
    check("dual_drained", 64'(sb.size()), 64'd0);

    // Core busy writing for 3 strobes; copy wraps src FFFF->0000.
    set_ch(1, 2'b00, 16'hFFFF, 16'h3000, 8'd2);
    sync_parity(0, 4);
    push_copy(16'hFFFF, 16'h3000, 2, 1'b0, 1'b0);
    clear_counts();
    I_cpu_rdwr = 1'b0;
    pulse_req(2'b10, 2'b00);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("stall_no_bus", {62'd0, O_bus_en, O_ready}, {62'd0, 1'b0, 1'b0});
    end
    I_cpu_rdwr = 1'b1;
    wait_done(1, 200);
    check("stall_cycles", 64'(bus_cycles), 64'd4);
    check("stall_ready_low", 64'(ready_low), 64'd8);
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Reset during the write of byte 5.
    set_ch(0, 2'b00, 16'h0600, 16'h0700, 8'd10);
    sync_parity(0, 1);
    push_copy(16'h0600, 16'h0700, 10, 1'b0, 1'b0);
    clear_counts();
    pulse_req(2'b01, 2'b00);
    begin
      int n;
      n = 0;
      while (!(O_bus_en && !O_rdwr && O_addr == 16'h0704) && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("reached_byte5", 64'(O_addr), 64'h0704);
    end
    #1 I_reset = 1'b0;
    #1 check_reset_outs("async_reset");
    sb.delete();
    @(negedge clk);
    I_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("no_done_reset", 64'(done0 + done1), 64'd0);

    set_ch(0, 2'b00, 16'h0800, 16'h0900, 8'd2);
    sync_parity(0, 1);
    push_copy(16'h0800, 16'h0900, 2, 1'b0, 1'b0);
    clear_counts();
    pulse_req(2'b01, 2'b00);
    wait_done(1, 200);
    check("after_rst_cycles", 64'(bus_cycles), 64'd4);
    check("after_rst_done", 64'(done0), 64'd1);
    check("after_rst_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
